// File: rtl/bst_pkg.sv
// Shared definitions for the tree command path: opcodes, frame sync nibble
// and the parser state encoding.
package bst_pkg;

  localparam logic [1:0] OP_INSERT = 2'd0;
  localparam logic [1:0] OP_DELETE = 2'd1;
  localparam logic [1:0] OP_SEARCH = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    KEY   = 2'd1,
    VAL   = 2'd2,
    ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/bst_cmd_parser.sv
// Drains the command FIFO byte stream, assembles framed tree commands and
// hands them to the tree engine over valid/ready; malformed headers are dropped.
module bst_cmd_parser
  import bst_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int KEY_BYTES = 2,
  parameter int VAL_BYTES = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [BYTE_W-1:0]             fifo_data,
  input  logic                          fifo_empty,
  output logic                          fifo_pull,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [1:0]                    cmd_op,
  output logic [KEY_BYTES*BYTE_W-1:0]   cmd_key,
  output logic [VAL_BYTES*BYTE_W-1:0]   cmd_val,
  output logic                          hdr_err
);

  localparam int MAX_BYTES = (KEY_BYTES > VAL_BYTES) ? KEY_BYTES : VAL_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES) + 1;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] VAL_LAST = CNT_W'(VAL_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hdr_ok;

  assign hdr_ok = (fifo_data[7:4] == SYNC_NIBBLE) && (fifo_data[3:2] == 2'b00);

  // Held low in reset so nothing is popped while the parser is discarding state.
  assign fifo_pull = aresetn && !fifo_empty && (state != ISSUE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= HDR;
      cnt       <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_INSERT;
      cmd_key   <= '0;
      cmd_val   <= '0;
      hdr_err   <= 1'b0;
    end else begin
      hdr_err <= 1'b0;
      case (state)
        HDR: begin
          if (fifo_pull) begin
            if (hdr_ok) begin
              cmd_op  <= fifo_data[1:0];
              cmd_key <= '0;
              cmd_val <= '0;
              cnt     <= '0;
              if (fifo_data[1:0] == OP_CLEAR) begin
                state     <= ISSUE;
                cmd_valid <= 1'b1;
              end else begin
                state <= KEY;
              end
            end else begin
              hdr_err <= 1'b1;
            end
          end
        end
        KEY: begin
          if (fifo_pull) begin
            // Little-endian: lane 0 is the first payload byte received.
            for (int i = 0; i < KEY_BYTES; i++) begin
              if (cnt == CNT_W'(i)) cmd_key[i*BYTE_W +: BYTE_W] <= fifo_data;
            end
            if (cnt == KEY_LAST) begin
              cnt <= '0;
              if (cmd_op == OP_INSERT) begin
                state <= VAL;
              end else begin
                state     <= ISSUE;
                cmd_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        VAL: begin
          if (fifo_pull) begin
            for (int i = 0; i < VAL_BYTES; i++) begin
              if (cnt == CNT_W'(i)) cmd_val[i*BYTE_W +: BYTE_W] <= fifo_data;
            end
            if (cnt == VAL_LAST) begin
              cnt       <= '0;
              state     <= ISSUE;
              cmd_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= HDR;
          end
        end
        default: begin
          state     <= HDR;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bst_cmd_parser.sv
// Bench for bst_cmd_parser: a byte-queue FIFO feeds frames built from
// (op, key, value) tuples; accepted commands are matched against the tuples.
module tb_bst_cmd_parser;
  import bst_pkg::*;

  localparam int BYTE_W    = 8;
  localparam int KEY_BYTES = 2;
  localparam int VAL_BYTES = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] key;
    logic [31:0] val;
  } cmd_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_pull;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_key;
  logic [31:0] cmd_val;
  logic        hdr_err;

  bst_cmd_parser #(.BYTE_W(BYTE_W), .KEY_BYTES(KEY_BYTES), .VAL_BYTES(VAL_BYTES)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pull  (fifo_pull),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_key    (cmd_key),
    .cmd_val    (cmd_val),
    .hdr_err    (hdr_err)
  );

  always #5 aclk = ~aclk;

  logic [7:0] fifo_q[$];
  cmd_t       exp_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, pulls = 0, hdr_errs = 0, exp_errs = 0, cmds = 0;
  int first_pull, last_pull, valid_rise, valid_cycles, err_cyc;
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int starve_mode = 0;  // 0: none, 1: random gaps, 2: one byte every 3 cycles
  bit hold = 1'b0, prev_valid = 1'b0;
  cmd_t hold_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    first_pull = -1; last_pull = -1; valid_rise = -1; valid_cycles = 0; err_cyc = -1;
  endtask

  task automatic push_frame(input logic [1:0] op, input logic [15:0] key, input logic [31:0] val);
    cmd_t c;
    fifo_q.push_back({SYNC_NIBBLE, 2'b00, op});
    if (op != OP_CLEAR)
      for (int k = 0; k < KEY_BYTES; k++) fifo_q.push_back(key[8*k +: 8]);
    if (op == OP_INSERT)
      for (int v = 0; v < VAL_BYTES; v++) fifo_q.push_back(val[8*v +: 8]);
    c.op  = op;
    c.key = (op == OP_CLEAR) ? 16'h0 : key;
    c.val = (op == OP_INSERT) ? val : 32'h0;
    exp_q.push_back(c);
  endtask

  task automatic push_bad(input logic [7:0] b);
    logic [7:0] x;
    x = b;
    if (x[7:4] == SYNC_NIBBLE && x[3:2] == 2'b00) x[2] = 1'b1;
    fifo_q.push_back(x);
    exp_errs++;
  endtask

  task automatic drive();
    logic starve;
    case (starve_mode)
      1:       starve = ($urandom_range(0, 2) == 0);
      2:       starve = (cyc % 3 != 0);
      default: starve = 1'b0;
    endcase
    fifo_empty = starve || (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : fifo_q[0];
    case (ready_mode)
      1:       cmd_ready = 1'b0;
      2:       cmd_ready = 1'($urandom);
      default: cmd_ready = 1'b1;
    endcase
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, then
  // account for what the rising edge will consume.
  task automatic tick();
    cmd_t got, e;
    drive();
    #1;
    if (fifo_empty) chk("pull_while_empty", {63'd0, fifo_pull}, 64'd0);
    if (hold) begin
      chk("valid_withdrawn", {63'd0, cmd_valid}, 64'd1);
      chk("hold_stable", {14'd0, cmd_op, cmd_key, cmd_val}, {14'd0, hold_v});
    end
    if (hdr_err) begin
      hdr_errs++;
      if (err_cyc < 0) err_cyc = cyc;
    end
    if (cmd_valid && !prev_valid) valid_rise = cyc;
    if (cmd_valid) valid_cycles++;
    prev_valid = cmd_valid;
    if (cmd_valid && cmd_ready) begin
      got = {cmd_op, cmd_key, cmd_val};
      chk("cmd_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cmd_fields", {14'd0, got}, {14'd0, e});
      end
      cmds++;
    end
    hold = cmd_valid && !cmd_ready;
    hold_v = {cmd_op, cmd_key, cmd_val};
    if (fifo_pull) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pulls++;
      if (first_pull < 0) first_pull = cyc;
      last_pull = cyc;
    end
    @(negedge aclk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_cmds_left", 64'(exp_q.size()), 64'd0);
    chk("drain_bytes_left", 64'(fifo_q.size()), 64'd0);
  endtask

  initial begin
    int n, p;
    logic [1:0] op;
    aresetn = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00; cmd_ready = 1'b0;
    clear_stats();
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_outputs", {47'd0, fifo_pull, cmd_valid, cmd_op, hdr_err, 12'd0},
        {47'd0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0});
    chk("rst_key_val", {16'd0, cmd_key, cmd_val}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // INSERT: 7 consecutive pops, valid the following cycle for one cycle
    clear_stats();
    push_frame(OP_INSERT, 16'h1234, 32'hDEADBEEF);
    drain(40);
    chk("ins_pull_span", 64'(last_pull - first_pull), 64'd6);
    chk("ins_latency", 64'(valid_rise - last_pull), 64'd1);
    chk("ins_valid_width", 64'(valid_cycles), 64'd1);

    // SEARCH held by backpressure with another frame queued behind it
    clear_stats();
    ready_mode = 1;
    push_frame(OP_SEARCH, 16'hABCD, 32'h0);
    push_frame(OP_CLEAR, 16'h0, 32'h0);
    n = 0;
    while (!cmd_valid && n < 20) begin tick(); n++; end
    chk("bp_valid_seen", {63'd0, cmd_valid}, 64'd1);
    p = pulls;
    repeat (5) tick();
    chk("bp_no_pull", 64'(pulls), 64'(p));
    chk("bp_op_key", {46'd0, cmd_op, cmd_key}, {46'd0, OP_SEARCH, 16'hABCD});
    ready_mode = 0;
    drain(40);

    // bad header then DELETE
    clear_stats();
    push_bad(8'h55);
    push_frame(OP_DELETE, 16'h0001, 32'h0);
    drain(40);
    chk("bad_err_latency", 64'(err_cyc - first_pull), 64'd1);
    chk("bad_err_count", 64'(hdr_errs), 64'(exp_errs));

    // CLEAR back-to-back
    clear_stats();
    p = cmds;
    push_frame(OP_CLEAR, 16'h0, 32'h0);
    push_frame(OP_CLEAR, 16'h0, 32'h0);
    drain(40);
    chk("clr_pull_span", 64'(last_pull - first_pull), 64'd2);
    chk("clr_cmds", 64'(cmds - p), 64'd2);

    // starved stream: one byte every 3 cycles
    clear_stats();
    starve_mode = 2;
    push_frame(OP_INSERT, 16'($urandom), 32'($urandom));
    drain(100);
    starve_mode = 0;

    // reset mid-frame
    fifo_q.push_back(8'hA0); fifo_q.push_back(8'h34); fifo_q.push_back(8'h12);
    repeat (2) tick();
    drive();
    aresetn = 1'b0;
    #2;
    chk("mid_rst_outputs", {60'd0, fifo_pull, cmd_valid, hdr_err, fifo_empty},
        {60'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("mid_rst_regs", {14'd0, cmd_op, cmd_key, cmd_val}, 64'd0);
    fifo_q.delete();
    hold = 1'b0; prev_valid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    push_frame(OP_SEARCH, 16'h0201, 32'h0);
    drain(40);

    // randomized traffic with random backpressure, gaps and bad headers
    ready_mode = 2;
    starve_mode = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) push_bad(8'($urandom));
      op = 2'($urandom);
      push_frame(op, 16'($urandom), 32'($urandom));
    end
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < 3000) begin
      tick();
      n++;
    end
    chk("rand_cmds_left", 64'(exp_q.size()), 64'd0);
    chk("rand_err_count", 64'(hdr_errs), 64'(exp_errs));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bst_cmd_parser.md
Name: bst_cmd_parser

Overview:
- Sits directly downstream of the single-clock command FIFO; drains its byte stream and assembles framed tree commands (opcode, key, value).
- Presents each complete command to the tree engine over a valid/ready handshake.
- Flags and drops malformed headers so that one bad byte never stalls the stream.

Parameters:
- BYTE_W, 8, FIFO data width; byte size of every frame field.
- KEY_BYTES, 2, number of key bytes per frame (key width = KEY_BYTES*BYTE_W).
- VAL_BYTES, 4, number of value bytes per INSERT frame (value width = VAL_BYTES*BYTE_W).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- fifo_data  in  BYTE_W  FIFO head byte; valid whenever fifo_empty=0 (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_pull  out  1  pops FIFO head this cycle.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  engine accepts the command.
- cmd_op  out  2  0=INSERT, 1=DELETE, 2=SEARCH, 3=CLEAR.
- cmd_key  out  KEY_BYTES*BYTE_W  assembled key.
- cmd_val  out  VAL_BYTES*BYTE_W  assembled value; zero for non-INSERT.
- hdr_err  out  1  one-cycle pulse: bad header byte dropped.

Behaviour:
- Interface: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: state=HDR, fifo_pull=0, cmd_valid=0, cmd_op=0, cmd_key=0, cmd_val=0, hdr_err=0, byte counter=0.
- Frame format, byte 0 = header:
  - bits[7:4] must be 0xA (sync nibble).
  - bits[1:0] = opcode; bits[3:2] must be 0.
- Payload bytes per opcode:
  - INSERT: KEY_BYTES key bytes, then VAL_BYTES value bytes.
  - DELETE, SEARCH: KEY_BYTES key bytes.
  - CLEAR: no payload.
- Payload multi-byte fields are little-endian: the first byte received lands in bits [BYTE_W-1:0].
- fifo_pull is combinational: fifo_pull = !fifo_empty && state in {HDR, KEY, VAL}. Never asserted in ISSUE or while fifo_empty=1.
- One byte consumed per cycle when data is available; a stalled FIFO (empty) freezes state and counter.
- FSM:
  - HDR:
    - Valid header popped -> latch op, clear key/val regs, counter=0.
    - Next state: KEY for INSERT/DELETE/SEARCH; ISSUE for CLEAR.
    - Invalid header popped -> hdr_err=1 next cycle, remain HDR (byte discarded, resync on next byte).
  - KEY: each pop writes byte into lane[counter]. On counter==KEY_BYTES-1: counter=0; go to VAL if INSERT, else ISSUE.
  - VAL: each pop writes value lane[counter]. On counter==VAL_BYTES-1: go to ISSUE.
  - ISSUE: cmd_valid=1; cmd_op/key/val stable until handshake. On cmd_valid&&cmd_ready, go to HDR and drop cmd_valid the next cycle.
- Latency: cmd_valid rises the cycle after the last frame byte is popped. Minimum frame period = frame bytes + 1 cycle.
- cmd_ready high before cmd_valid has no effect. The parser never withdraws cmd_valid before acceptance.
- Counter width is $clog2 of max(KEY_BYTES, VAL_BYTES) plus 1; it saturates at no value other than its terminal count.
- Mid-frame reset: all state is discarded immediately; bytes already popped are lost; parsing restarts at HDR.
- No timeout: a partial frame waits indefinitely for the FIFO.

Decomposition:
- Shared package bst_pkg holds:
  - opcode localparams (OP_INSERT=2'd0, OP_DELETE=2'd1, OP_SEARCH=2'd2, OP_CLEAR=2'd3)
  - SYNC_NIBBLE=4'hA
  - FSM state encoding (HDR, KEY, VAL, ISSUE)
- Single module, no sub-module; the byte-lane shift/assembly stays inline.

Test Plan:
- INSERT: FIFO holds A0,34,12,EF,BE,AD,DE, cmd_ready=1 -> 7 consecutive pulls; next cycle cmd_valid=1, op=0, key=0x1234, val=0xDEADBEEF; one-cycle valid.
- SEARCH with backpressure: A2,CD,AB, cmd_ready=0 for 5 cycles -> cmd_valid held 5+ cycles with op=2, key=0xABCD, val=0; fifo_pull=0 throughout; accepted on cmd_ready=1.
- Bad header then DELETE: 55,A1,01,00 -> hdr_err pulse one cycle after 0x55 pop; then op=1, key=0x0001 issued.
- CLEAR back-to-back: A3,A3 with cmd_ready=1 -> two commands op=3, each following one pop cycle; no lost frame.
- Starved stream: A0 followed by bytes one every 3 cycles -> fifo_pull only when fifo_empty=0; final command matches the full INSERT frame.
- Reset mid-frame: aresetn low after A0,34 -> all outputs 0 asynchronously; after release, frame A2,01,02 yields op=2, key=0x0201.
